hcsr04_controller: RTL and testbench

Host-side driver for the HC-SR04 ultrasonic ranger. On request, it issues the trigger pulse, times the returned echo pulse, and reports the echo width both in raw clock cycles and in centimetres via a prescaler. It sits between the sensor pins and the application logic and handles timeouts and the sensor's mandatory re-trigger holdoff.

---
 rtl/hcsr04_controller.sv | 170 +++++++++++++++++
 tb/tb_hcsr04_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_controller.sv
// HC-SR04 ranger driver: issues trigger, times echo, reports raw cycles and cm; enforces timeout and re-trigger holdoff.
// Continuous measurement when HCSR04_AUTO_RETRIGGER_EN is defined (HOLDOFF loops to TRIG instead of IDLE).
module hcsr04_controller #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int HOLDOFF_CYCLES = 3000000,
    parameter int CNT_WIDTH      = 24,
    parameter int DIST_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  trigger,
    input  logic                  echo,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  echo_cycles,
    output logic [DIST_WIDTH-1:0] distance_cm,
    output logic                  valid,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TRIG_LAST = CNT_WIDTH'(TRIG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CM_LAST   = CNT_WIDTH'(CYCLES_PER_CM - 1);

    state_t                  state_q;
    logic                    echo_meta_q;
    logic                    echo_s_q;
    logic                    echo_prev_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    presc_q;
    logic [DIST_WIDTH-1:0]   cm_q;
    logic                    trigger_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [CNT_WIDTH-1:0]    echo_cycles_q;
    logic [DIST_WIDTH-1:0]   distance_q;
    logic                    echo_rise;
    logic                    echo_fall;

    assign echo_rise   = echo_s_q & ~echo_prev_q;
    assign echo_fall   = ~echo_s_q & echo_prev_q;

    assign trigger     = trigger_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign echo_cycles = echo_cycles_q;
    assign distance_cm = distance_q;

    // Both edges see the same 2-flop delay, so the measured width is unbiased.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            echo_prev_q <= echo_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            presc_q       <= '0;
            cm_q          <= '0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            echo_cycles_q <= '0;
            distance_q    <= '0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= TRIG;
                        trigger_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        state_q   <= WAIT_ECHO;
                        trigger_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= CNT_WIDTH'(1);
                        presc_q <= '0;
                        cm_q    <= '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= HOLDOFF;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        state_q       <= HOLDOFF;
                        echo_cycles_q <= cnt_q;
                        distance_q    <= cm_q;
                        valid_q       <= 1'b1;
                        cnt_q         <= '0;
                    end else if (cnt_q >= TMO_LAST) begin
                        // This cycle would be the TIMEOUT_CYCLES-th echo cycle.
                        state_q   <= HOLDOFF;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (presc_q == CM_LAST) begin
                            presc_q <= '0;
                            if (cm_q != {DIST_WIDTH{1'b1}}) begin
                                cm_q <= cm_q + 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
`ifdef HCSR04_AUTO_RETRIGGER_EN
                        state_q   <= TRIG;
                        trigger_q <= 1'b1;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    trigger_q <= 1'b0;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_controller.sv
// Directed bench for hcsr04_controller with a small sensor model that answers each trigger with an echo pulse.
module tb_hcsr04_controller;

    localparam int TRIG = 4;
    localparam int CPC  = 2;
    localparam int TMO  = 40;
    localparam int HOLD = 8;
    localparam int CW   = 24;
    localparam int DW   = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          echo  = 1'b0;
    logic          trigger;
    logic          busy;
    logic          valid;
    logic          timeout;
    logic [CW-1:0] echo_cycles;
    logic [DW-1:0] distance_cm;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hcsr04_controller #(
        .TRIG_CYCLES    (TRIG),
        .CYCLES_PER_CM  (CPC),
        .TIMEOUT_CYCLES (TMO),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_WIDTH      (CW),
        .DIST_WIDTH     (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trigger     (trigger),
        .echo        (echo),
        .busy        (busy),
        .echo_cycles (echo_cycles),
        .distance_cm (distance_cm),
        .valid       (valid),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int cyc = 0, trig_rises = 0, trig_len = 0, last_trig_len = 0, trig_fall_cyc = 0;
    int valid_cnt = 0, valid_cyc = 0, tmo_cnt = 0, tmo_cyc = 0, both_cnt = 0;
    int busy_fall_cyc = 0, rise_gap = -1;
    logic [CW-1:0] v_ec = '0;
    logic [DW-1:0] v_dist = '0;
    logic trig_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (trigger && !trig_prev) begin
            trig_rises++;
            trig_len = 0;
            if (valid_cnt > 0) rise_gap = cyc - valid_cyc;
        end
        if (trigger) trig_len++;
        if (!trigger && trig_prev) begin
            last_trig_len = trig_len;
            trig_fall_cyc = cyc;
        end
        trig_prev = trigger;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = busy;
        if (valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            v_ec      = echo_cycles;
            v_dist    = distance_cm;
        end
        if (timeout) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
        if (valid && timeout) both_cnt++;
    end

    // Sensor model: echo rises echo_dly cycles after trigger falls, stays high echo_len cycles (0 = silent).
    int   echo_len = 11;
    int   echo_dly = 1;
    int   s_cnt = 0, s_hi = 0;
    bit   s_pend = 1'b0;
    logic s_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            echo   = 1'b0;
            s_pend = 1'b0;
        end else if (echo) begin
            s_hi--;
            if (s_hi == 0) echo = 1'b0;
        end else if (s_pend) begin
            s_cnt--;
            if (s_cnt == 0) begin
                s_pend = 1'b0;
                echo   = 1'b1;
                s_hi   = echo_len;
            end
        end
        if (rst_n && s_prev && !trigger && echo_len > 0) begin
            s_pend = 1'b1;
            s_cnt  = echo_dly;
        end
        s_prev = trigger;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 0);
        tick(1);
    endtask

    initial begin
        int base_rises;
        int base_valid;
        int k;

        tick(3);
        check("rst_trigger", trigger, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_echo_cycles", echo_cycles, 0);
        check("rst_distance", distance_cm, 0);
        rst_n = 1'b1;
        tick(2);

`ifdef HCSR04_AUTO_RETRIGGER_EN
        echo_len = 11;
        pulse_start();
        tick(150);
        check("auto_trig_rises", trig_rises >= 4, 1);
        check("auto_valid_cnt", valid_cnt >= 4, 1);
        check("auto_distance", v_dist, 5);
        check("auto_ec_range", (v_ec >= 10 && v_ec <= 12), 1);
        check("auto_trig_len", last_trig_len, TRIG);
        check("auto_holdoff_gap", rise_gap, HOLD);
        check("auto_no_timeout", tmo_cnt, 0);
        check("auto_busy", busy, 1);
        check("auto_no_overlap", both_cnt, 0);
        check("auto_valid_vs_rises", (trig_rises - valid_cnt) <= 1, 1);
`else
        // Normal measurement.
        echo_len = 11;
        pulse_start();
        wait_idle("t1_idle", 200);
        check("t1_trig_len", last_trig_len, TRIG);
        check("t1_trig_rises", trig_rises, 1);
        check("t1_valid_cnt", valid_cnt, 1);
        check("t1_ec_range", (v_ec >= 10 && v_ec <= 12), 1);
        check("t1_distance", v_dist, 5);
        check("t1_busy_after_valid", busy_fall_cyc - valid_cyc, HOLD);
        check("t1_no_timeout", tmo_cnt, 0);

        // Silent sensor.
        echo_len = 0;
        pulse_start();
        wait_idle("t2_idle", 200);
        check("t2_tmo_cnt", tmo_cnt, 1);
        check("t2_tmo_delay", tmo_cyc - trig_fall_cyc, TMO);
        check("t2_valid_cnt", valid_cnt, 1);
        check("t2_ec_hold", (echo_cycles >= 10 && echo_cycles <= 12), 1);
        check("t2_dist_hold", distance_cm, 5);

        // Echo stuck high past the timeout.
        echo_len = 60;
        pulse_start();
        wait_idle("t3_idle", 300);
        check("t3_tmo_cnt", tmo_cnt, 2);
        check("t3_valid_cnt", valid_cnt, 1);
        check("t3_dist_hold", distance_cm, 5);
        check("t3_no_overlap", both_cnt, 0);
        tick(30);

        // start during TRIG, MEASURE and HOLDOFF is dropped.
        echo_len   = 11;
        base_rises = trig_rises;
        base_valid = valid_cnt;
        pulse_start();
        pulse_start();
        k = 0;
        while (!echo && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_echo_seen", echo, 1);
        tick(5);
        pulse_start();
        k = 0;
        while (valid_cnt == base_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_valid_seen", valid_cnt, base_valid + 1);
        pulse_start();
        wait_idle("t4_idle", 100);
        tick(20);
        check("t4_one_trigger", trig_rises, base_rises + 1);
        check("t4_one_valid", valid_cnt, base_valid + 1);
        check("t4_stays_idle", busy, 0);
        check("t4_distance", v_dist, 5);

        // Reset while trigger is high.
        pulse_start();
        check("t5_trig_high", trigger, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_trig_async_low", trigger, 0);
        check("t5_busy_low", busy, 0);
        tick(2);
        check("t5_ec_reset", echo_cycles, 0);
        check("t5_dist_reset", distance_cm, 0);
        check("t5_valid_reset", valid, 0);
        check("t5_tmo_reset", timeout, 0);
        rst_n = 1'b1;
        tick(2);
        base_valid = valid_cnt;
        pulse_start();
        wait_idle("t5_idle", 200);
        check("t5_valid_cnt", valid_cnt, base_valid + 1);
        check("t5_distance", v_dist, 5);
        check("t5_ec_range", (v_ec >= 10 && v_ec <= 12), 1);
        check("t5_trig_len", last_trig_len, TRIG);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
